trigger_detect_mc: RTL and testbench

Parametrised multi-channel successor of the single-channel FFT trigger. It sinks the FFT result AXI-stream, where each beat is tagged with a bin index and a channel id. A frame qualifies when any bin in a programmable window exceeds the threshold. A trigger fires after a programmable number of consecutive qualifying frames on one channel, followed by a programmable holdoff. It sits between the FFT core and the capture/ping-timing logic, and reports channel, peak bin and peak value with each trigger.

---
 rtl/trigger_pkg.sv | 12 +
 rtl/trigger_ch_tracker.sv | 52 +++++
 rtl/trigger_detect_mc.sv | 121 ++++++++++++
 tb/tb_trigger_detect_mc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// trigger_pkg: shared state encoding, default widths and t_user field offsets for the multi-channel trigger
package trigger_pkg;
  typedef enum logic {ST_ARMED = 1'b0, ST_HOLDOFF = 1'b1} state_e;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_BIN_W    = 8;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CH_W     = 2;
  localparam int DEF_CNT_W    = 4;
  localparam int USER_BIN_LSB = 0;
  localparam int USER_W       = 16;
  localparam int TDATA_W      = 32;
endpackage

// File: rtl/trigger_ch_tracker.sv
// trigger_ch_tracker: one channel's hit flag, running peak and consecutive-hit-frame counter
module trigger_ch_tracker
  import trigger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BIN_W  = DEF_BIN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              beat_en,
  input  logic              last_en,
  input  logic              clr_all,
  input  logic              hit_i,
  input  logic [DATA_W-1:0] val_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic [CNT_W-1:0]  consec_upd_o,
  output logic [DATA_W-1:0] peak_val_o,
  output logic [BIN_W-1:0]  peak_bin_o
);
  logic              hit_flag_q, hit_flag_d;
  logic [DATA_W-1:0] peak_val_q, peak_val_d;
  logic [BIN_W-1:0]  peak_bin_q, peak_bin_d;
  logic [CNT_W-1:0]  consec_q, consec_d;
  logic              load;
  // A hit replaces the peak only when strictly larger, so equal values keep the earlier (lower) bin
  assign load         = hit_i && (!hit_flag_q || val_i > peak_val_q);
  assign peak_val_o   = load ? val_i : peak_val_q;
  assign peak_bin_o   = load ? bin_i : peak_bin_q;
  assign consec_upd_o = !(hit_flag_q || hit_i) ? '0 : (&consec_q) ? consec_q : consec_q + 1'b1;
  // Next state: accumulate within a frame, reset the frame tracking on t_last
  always_comb begin
    hit_flag_d = beat_en ? (hit_flag_q || hit_i) && !last_en : hit_flag_q;
    peak_val_d = !beat_en ? peak_val_q : last_en ? '0 : peak_val_o;
    peak_bin_d = beat_en ? peak_bin_o : peak_bin_q;
    consec_d   = clr_all ? '0 : last_en ? consec_upd_o : consec_q;
  end
  // Channel state registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hit_flag_q <= 1'b0;
      peak_val_q <= '0;
      peak_bin_q <= '0;
      consec_q   <= '0;
    end else begin
      hit_flag_q <= hit_flag_d;
      peak_val_q <= peak_val_d;
      peak_bin_q <= peak_bin_d;
      consec_q   <= consec_d;
    end
  end
endmodule

// File: rtl/trigger_detect_mc.sv
// trigger_detect_mc: multi-channel FFT frame trigger with consecutive-frame qualification and holdoff
module trigger_detect_mc
  import trigger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BIN_W  = DEF_BIN_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic [TDATA_W-1:0] t_data,
  input  logic               t_valid,
  input  logic               t_last,
  input  logic [USER_W-1:0]  t_user,
  output logic               t_ready,
  input  logic               enable,
  input  logic [DATA_W-1:0]  threshold,
  input  logic [BIN_W-1:0]   win_lo,
  input  logic [BIN_W-1:0]   win_hi,
  input  logic [CNT_W-1:0]   min_frames,
  input  logic [15:0]        holdoff_cycles,
  output logic               trigger,
  output logic [CH_W-1:0]    trig_ch,
  output logic [BIN_W-1:0]   trig_bin,
  output logic [DATA_W-1:0]  trig_peak,
  output logic               frame_done,
  output logic [CH_W-1:0]    frame_ch,
  output logic               armed
);
  logic              t_ready_q, trigger_q, frame_done_q, armed_q;
  logic [CH_W-1:0]   trig_ch_q, frame_ch_q;
  logic [BIN_W-1:0]  trig_bin_q;
  logic [DATA_W-1:0] trig_peak_q;
  state_e            state_q;
  logic [15:0]       hold_q;
  logic              accept, last_acc, hit, fire;
  logic [BIN_W-1:0]  bin;
  logic [CH_W-1:0]   ch;
  logic [CNT_W-1:0]  min_eff;
  logic [CNT_W-1:0]  upd [NUM_CH];
  logic [DATA_W-1:0] pk_val [NUM_CH];
  logic [BIN_W-1:0]  pk_bin [NUM_CH];
  logic              unused_bits;
  assign unused_bits = ^{t_data[TDATA_W-1:DATA_W], t_user[USER_W-1:USER_BIN_LSB+BIN_W+CH_W]};
  assign accept   = t_valid && t_ready_q;
  assign last_acc = accept && t_last;
  assign bin      = t_user[USER_BIN_LSB +: BIN_W];
  assign ch       = t_user[USER_BIN_LSB+BIN_W +: CH_W];
  // Positive sample strictly above threshold inside the inclusive window; an inverted window never matches
  assign hit      = accept && !t_data[DATA_W-1] && t_data[DATA_W-1:0] > threshold && bin >= win_lo && bin <= win_hi;
  assign min_eff  = min_frames | CNT_W'(min_frames == '0);
  assign fire     = last_acc && enable && state_q == ST_ARMED && upd[ch] >= min_eff;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trigger_ch_tracker #(.DATA_W(DATA_W), .BIN_W(BIN_W), .CNT_W(CNT_W)) u_trk (
      .clk          (clk),
      .reset_b      (reset_b),
      .beat_en      (accept && ch == CH_W'(i)),
      .last_en      (last_acc && ch == CH_W'(i)),
      .clr_all      (fire || !enable),
      .hit_i        (hit),
      .val_i        (t_data[DATA_W-1:0]),
      .bin_i        (bin),
      .consec_upd_o (upd[i]),
      .peak_val_o   (pk_val[i]),
      .peak_bin_o   (pk_bin[i])
    );
  end
  // Registered outputs: ready after reset, per-frame and per-trigger reporting
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      t_ready_q    <= 1'b0;
      trigger_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ch_q   <= '0;
      trig_ch_q    <= '0;
      trig_bin_q   <= '0;
      trig_peak_q  <= '0;
    end else begin
      t_ready_q    <= 1'b1;
      trigger_q    <= fire;
      frame_done_q <= last_acc;
      if (last_acc) frame_ch_q <= ch;
      if (fire) begin
        trig_ch_q   <= ch;
        trig_bin_q  <= pk_bin[ch];
        trig_peak_q <= pk_val[ch];
      end
    end
  end
  // Holdoff FSM: counter loaded on trigger, back to ARMED the cycle it reads zero
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_ARMED;
      hold_q  <= '0;
      armed_q <= 1'b0;
    end else if (state_q == ST_ARMED) begin
      if (fire) begin
        state_q <= ST_HOLDOFF;
        hold_q  <= holdoff_cycles;
        armed_q <= 1'b0;
      end else begin
        armed_q <= 1'b1;
      end
    end else if (hold_q == '0) begin
      state_q <= ST_ARMED;
      armed_q <= 1'b1;
    end else begin
      hold_q <= hold_q - 1'b1;
    end
  end
  assign t_ready    = t_ready_q;
  assign trigger    = trigger_q;
  assign trig_ch    = trig_ch_q;
  assign trig_bin   = trig_bin_q;
  assign trig_peak  = trig_peak_q;
  assign frame_done = frame_done_q;
  assign frame_ch   = frame_ch_q;
  assign armed      = armed_q;
endmodule

// File: tb/tb_trigger_detect_mc.sv
// tb_trigger_detect_mc: table vectors, directed corner sequences and random traffic against a frame-level model
module tb_trigger_detect_mc;
  localparam int NCH = 4;
  logic        clk = 1'b0;
  logic        reset_b = 1'b1;
  logic [31:0] t_data = '0;
  logic        t_valid = 1'b0;
  logic        t_last = 1'b0;
  logic [15:0] t_user = '0;
  logic        t_ready;
  logic        enable = 1'b1;
  logic [15:0] threshold = 16'd1000;
  logic [7:0]  win_lo = 8'd16;
  logic [7:0]  win_hi = 8'd18;
  logic [3:0]  min_frames = 4'd1;
  logic [15:0] holdoff_cycles = 16'd10;
  logic        trigger, frame_done, armed;
  logic [1:0]  trig_ch, frame_ch;
  logic [7:0]  trig_bin;
  logic [15:0] trig_peak;

  trigger_detect_mc dut (
    .clk(clk), .reset_b(reset_b), .t_data(t_data), .t_valid(t_valid), .t_last(t_last),
    .t_user(t_user), .t_ready(t_ready), .enable(enable), .threshold(threshold),
    .win_lo(win_lo), .win_hi(win_hi), .min_frames(min_frames), .holdoff_cycles(holdoff_cycles),
    .trigger(trigger), .trig_ch(trig_ch), .trig_bin(trig_bin), .trig_peak(trig_peak),
    .frame_done(frame_done), .frame_ch(frame_ch), .armed(armed)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, ready_at = 1;
  int consec [NCH];
  int hv [NCH][$];
  int hb [NCH][$];
  bit e_trig, e_done;
  int e_fch, e_tch, e_tbin, e_tpk;

  typedef struct {
    bit v; int d; int b; int c; bit l;
    bit et; bit ed; int ebin; int epk;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", n, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    ready_at = 1;
    e_tch = 0; e_tbin = 0; e_tpk = 0;
    for (int k = 0; k < NCH; k++) begin
      consec[k] = 0;
      hv[k].delete();
      hb[k].delete();
    end
  endtask

  // One clock: drive a beat, predict from frame contents, then compare every output
  task automatic step(input bit v, input int d, input int b, input int c, input bit l);
    int d16, mn, pv, pb;
    bit hit;
    t_valid = v; t_data = d; t_user = 16'((c << 8) | b); t_last = l;
    e_trig = 0; e_done = 0;
    if (v && cyc >= 1) begin
      d16 = d & 'hffff;
      hit = d16 < 32768 && d16 > int'(threshold) && b >= int'(win_lo) && b <= int'(win_hi);
      if (hit) begin
        hv[c].push_back(d16);
        hb[c].push_back(b);
      end
      if (l) begin
        consec[c] = hv[c].size() == 0 ? 0 : (consec[c] >= 15 ? 15 : consec[c] + 1);
        e_done = 1; e_fch = c;
        mn = min_frames == 0 ? 1 : int'(min_frames);
        if (enable && cyc >= ready_at && consec[c] >= mn) begin
          pv = -1; pb = 0;
          for (int k = 0; k < hv[c].size(); k++)
            if (hv[c][k] > pv || (hv[c][k] == pv && hb[c][k] < pb)) begin
              pv = hv[c][k]; pb = hb[c][k];
            end
          e_trig = 1; e_tch = c; e_tbin = pb; e_tpk = pv;
          for (int k = 0; k < NCH; k++) consec[k] = 0;
          ready_at = cyc + 2 + int'(holdoff_cycles);
        end
        hv[c].delete();
        hb[c].delete();
      end
    end
    if (!enable) for (int k = 0; k < NCH; k++) consec[k] = 0;
    @(posedge clk);
    #1;
    cyc++;
    chk("trigger", trigger, e_trig);
    chk("frame_done", frame_done, e_done);
    if (e_done) chk("frame_ch", frame_ch, e_fch);
    chk("trig_ch", trig_ch, e_tch);
    chk("trig_bin", trig_bin, e_tbin);
    chk("trig_peak", trig_peak, e_tpk);
    chk("armed", armed, cyc >= ready_at);
    chk("t_ready", t_ready, 1);
    t_valid = 0; t_last = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_b = 0; t_valid = 0; t_last = 0;
    #1;
    chk("rst_t_ready", t_ready, 0);
    chk("rst_armed", armed, 0);
    chk("rst_trigger", trigger, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_trig_peak", trig_peak, 0);
    @(posedge clk);
    #1;
    chk("rst_t_ready_hold", t_ready, 0);
    reset_b = 1;
    model_reset();
    chk("release_t_ready", t_ready, 0);
  endtask

  task automatic wait_armed();
    int n = 0;
    while (armed !== 1'b1 && n < 500) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    chk("wait_armed", armed, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int hc, n, nb [NCH];
    do_reset();
    step(0, 0, 0, 0, 0);

    // Single qualifying ch1 frame, then a frame whose only in-window sample is negative
    tbl[0] = '{1, 0,       15, 1, 0, 0, 0, 0,  0};
    tbl[1] = '{1, 0,       16, 1, 0, 0, 0, 0,  0};
    tbl[2] = '{1, 1500,    17, 1, 0, 0, 0, 0,  0};
    tbl[3] = '{1, 0,       18, 1, 1, 1, 1, 17, 1500};
    tbl[4] = '{1, 'h9000,  17, 1, 0, 0, 0, 17, 1500};
    tbl[5] = '{1, 5000,    20, 1, 1, 0, 1, 17, 1500};
    for (int i = 0; i < 6; i++) begin
      if (i == 4) repeat (12) step(0, 0, 0, 0, 0);
      step(tbl[i].v, tbl[i].d, tbl[i].b, tbl[i].c, tbl[i].l);
      chk("tbl_trigger", trigger, tbl[i].et);
      chk("tbl_frame_done", frame_done, tbl[i].ed);
      chk("tbl_trig_bin", trig_bin, tbl[i].ebin);
      chk("tbl_trig_peak", trig_peak, tbl[i].epk);
    end
    chk("tbl_trig_ch", trig_ch, 1);

    // min_frames=3 on ch2: hit, hit, miss, hit, hit, hit
    wait_armed();
    min_frames = 3;
    for (int f = 0; f < 6; f++) begin
      step(1, f == 2 ? 0 : 2000, 17, 2, 1);
      chk("seqA_trigger", trigger, f == 5);
    end

    // Interleaved ch0/ch3; ch3 completes inside a 20-cycle holdoff
    wait_armed();
    min_frames = 1;
    holdoff_cycles = 20;
    step(1, 2000, 16, 0, 0);
    step(1, 3000, 16, 3, 0);
    step(1, 0, 17, 0, 1);
    chk("seqB_trigger_ch0", trigger, 1);
    chk("seqB_trig_ch", trig_ch, 0);
    hc = armed ? 0 : 1;
    step(1, 0, 17, 3, 1);
    chk("seqB_trigger_ch3", trigger, 0);
    hc += armed ? 0 : 1;
    n = 0;
    while (!armed && n < 100) begin
      step(0, 0, 0, 0, 0);
      hc += armed ? 0 : 1;
      n++;
    end
    chk("seqB_holdoff_len", hc, 21);

    // Inverted window never hits; min_frames=0 acts as 1; holdoff=0 is one cycle
    wait_armed();
    holdoff_cycles = 0;
    threshold = 100;
    win_lo = 20; win_hi = 10;
    for (int b = 0; b < 32; b++) step(1, 30000, b, 3, b == 31);
    chk("seqC_inverted_window", trigger, 0);
    min_frames = 0;
    win_lo = 16; win_hi = 18;
    step(1, 30000, 17, 3, 1);
    chk("seqC_min0_trigger", trigger, 1);
    chk("seqC_h0_armed_lo", armed, 0);
    step(0, 0, 0, 0, 0);
    chk("seqC_h0_armed_hi", armed, 1);

    // Reset with a hit pending on ch1, then a hitless ch1 frame
    min_frames = 1;
    threshold = 1000;
    step(1, 5000, 17, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    step(1, 0, 18, 1, 1);
    chk("seqD_trigger", trigger, 0);
    chk("seqD_frame_done", frame_done, 1);

    // Random traffic
    for (int k = 0; k < NCH; k++) nb[k] = $urandom_range(0, 20);
    for (int i = 0; i < 3000; i++) begin
      int c, d16, tv;
      bit v, l;
      if (i % 250 == 0) begin
        threshold = 16'($urandom_range(0, 40000));
        win_lo = 8'($urandom_range(0, 30));
        win_hi = ($urandom_range(0, 7) == 0 && win_lo > 0) ? win_lo - 8'd1 : win_lo + 8'($urandom_range(0, 20));
        min_frames = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
        holdoff_cycles = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(100, 300)) : 16'($urandom_range(0, 15));
        enable = 1;
      end
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      c = $urandom_range(0, 3);
      tv = int'(threshold);
      case ($urandom_range(0, 4))
        0: d16 = tv;
        1: d16 = (tv + 1) & 'hffff;
        2: d16 = $urandom_range(0, 65535);
        3: d16 = 0;
        default: d16 = $urandom_range(tv, tv + 500) & 'hffff;
      endcase
      v = $urandom_range(0, 3) != 0;
      l = $urandom_range(0, 5) == 0 || nb[c] >= 250;
      step(v, ($urandom_range(0, 65535) << 16) | d16, nb[c], c, l);
      if (v) nb[c] = l ? $urandom_range(0, 20) : nb[c] + 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
